// File: rtl/exc_ctrl.sv
// Exception sequencer: decides IRQ/SWI entry and exception return, drives PSR backup/restore, LR write and PC redirect.
// Latency: decision on retire in cycle N, redirect from N+1; strobes combinational on the ack cycle. Optional macro: EXC_CTRL_IRQ_SYNC_EN.
// Backpressure: redirect/pc/lr held until i_redirect_ack & en; o_busy blocks further retires.
module exc_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_irq,
    input  logic        i_irq_mask,
    input  logic        i_int_mode,
    input  logic        i_retire,
    input  logic        i_swi,
    input  logic        i_eret,
    input  logic [31:0] i_next_pc,
    input  logic [31:0] i_lr,
    output logic        o_busy,
    output logic        o_redirect,
    output logic [31:0] o_pc,
    input  logic        i_redirect_ack,
    output logic        o_spsr_bak,
    output logic        o_spsr_res,
    output logic        o_lr_we,
    output logic [31:0] o_lr
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ENTER_IRQ = 2'd1,
        S_ENTER_SWI = 2'd2,
        S_RETURN    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ret_pc_q, ret_pc_d;
    logic        irq_vis;
    logic        irq_pend;
    logic        commit;

`ifdef EXC_CTRL_IRQ_SYNC_EN
    // Free-running synchronizer: must not stall with en, or a stalled core would see stale IRQ state.
    logic irq_meta_q, irq_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= i_irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign irq_vis = irq_sync_q;
`else
    assign irq_vis = i_irq;
`endif

    assign irq_pend = irq_vis & ~i_irq_mask;
    assign commit   = en & i_redirect_ack & (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        ret_pc_d = ret_pc_q;
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_retire) begin
                        // Synchronous events belong to the retiring instruction and win over IRQ.
                        if (i_swi) begin
                            state_d  = S_ENTER_SWI;
                            ret_pc_d = i_next_pc;
                        end else if (i_eret && i_int_mode) begin
                            state_d  = S_RETURN;
                            ret_pc_d = i_lr;
                        end else if (irq_pend) begin
                            state_d  = S_ENTER_IRQ;
                            ret_pc_d = i_next_pc;
                        end
                    end
                end
                default: begin
                    if (i_redirect_ack) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ret_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            ret_pc_q <= ret_pc_d;
        end
    end

    always_comb begin
        o_busy     = 1'b0;
        o_redirect = 1'b0;
        o_pc       = 32'h0;
        o_lr       = 32'h0;
        o_spsr_bak = 1'b0;
        o_spsr_res = 1'b0;
        o_lr_we    = 1'b0;
        case (state_q)
            S_ENTER_IRQ: begin
                o_busy     = 1'b1;
                o_redirect = 1'b1;
                o_pc       = VEC_BASE + 32'h18;
                o_lr       = ret_pc_q + 32'h4;
                o_spsr_bak = commit;
                o_lr_we    = commit;
            end
            S_ENTER_SWI: begin
                o_busy     = 1'b1;
                o_redirect = 1'b1;
                o_pc       = VEC_BASE + 32'h08;
                o_lr       = ret_pc_q;
                o_spsr_bak = commit;
                o_lr_we    = commit;
            end
            S_RETURN: begin
                o_busy     = 1'b1;
                o_redirect = 1'b1;
                o_pc       = ret_pc_q;
                o_spsr_res = commit;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VB = 32'h0000_0000;
`ifdef EXC_CTRL_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk, rst_n, en;
    logic        i_irq, i_irq_mask, i_int_mode, i_retire, i_swi, i_eret;
    logic [31:0] i_next_pc, i_lr;
    logic        o_busy, o_redirect, i_redirect_ack;
    logic [31:0] o_pc, o_lr;
    logic        o_spsr_bak, o_spsr_res, o_lr_we;

    int n_tests = 0;
    int n_fail  = 0;

    exc_ctrl #(.VEC_BASE(VB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_irq(i_irq), .i_irq_mask(i_irq_mask), .i_int_mode(i_int_mode),
        .i_retire(i_retire), .i_swi(i_swi), .i_eret(i_eret),
        .i_next_pc(i_next_pc), .i_lr(i_lr),
        .o_busy(o_busy), .o_redirect(o_redirect), .o_pc(o_pc),
        .i_redirect_ack(i_redirect_ack),
        .o_spsr_bak(o_spsr_bak), .o_spsr_res(o_spsr_res),
        .o_lr_we(o_lr_we), .o_lr(o_lr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending exception kind (0 none, 1 IRQ, 2 SWI, 3 return) plus its redirect target and LR value.
    int          m_kind;
    logic [31:0] m_pc, m_lr;
    logic        irq_hist [1:2];   // i_irq as sampled 1 and 2 cycles ago

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind = 0;
        m_pc = 32'h0;
        m_lr = 32'h0;
        irq_hist[1] = 1'b0;
        irq_hist[2] = 1'b0;
    endtask

    task automatic check_model();
        logic busy, commit;
        busy   = (m_kind != 0);
        commit = busy && i_redirect_ack && en;
        check("busy",     {63'h0, o_busy},     {63'h0, busy});
        check("redirect", {63'h0, o_redirect}, {63'h0, busy});
        check("pc",       {32'h0, o_pc},       {32'h0, m_pc});
        check("lr",       {32'h0, o_lr},       {32'h0, m_lr});
        check("spsr_bak", {63'h0, o_spsr_bak}, {63'h0, commit && (m_kind == 1 || m_kind == 2)});
        check("lr_we",    {63'h0, o_lr_we},    {63'h0, commit && (m_kind == 1 || m_kind == 2)});
        check("spsr_res", {63'h0, o_spsr_res}, {63'h0, commit && (m_kind == 3)});
    endtask

    task automatic model_advance();
        logic vis;
        vis = (LAT == 0) ? i_irq : irq_hist[2];
        if (en) begin
            if (m_kind != 0) begin
                if (i_redirect_ack) begin
                    m_kind = 0; m_pc = 32'h0; m_lr = 32'h0;
                end
            end else if (i_retire) begin
                if (i_swi) begin
                    m_kind = 2; m_pc = VB + 32'h08; m_lr = i_next_pc;
                end else if (i_eret && i_int_mode) begin
                    m_kind = 3; m_pc = i_lr; m_lr = 32'h0;
                end else if (vis && !i_irq_mask) begin
                    m_kind = 1; m_pc = VB + 32'h18; m_lr = i_next_pc + 32'h4;
                end
            end
        end
        irq_hist[2] = irq_hist[1];
        irq_hist[1] = i_irq;
    endtask

    // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 1'b1; i_retire = 1'b0; i_swi = 1'b0; i_eret = 1'b0;
        i_redirect_ack = 1'b0; i_next_pc = 32'h0; i_lr = 32'h0;
    endtask

    initial begin
        int first;
        rst_n = 1'b0; i_irq = 1'b0; i_irq_mask = 1'b0; i_int_mode = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {63'h0, o_busy}, 64'h0);
        check("rst_pc",   {32'h0, o_pc},   64'h0);
        check("rst_lr",   {32'h0, o_lr},   64'h0);
        check("rst_strb", {61'h0, o_spsr_bak, o_spsr_res, o_lr_we}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // IRQ entry with next_pc 0x100
        i_irq = 1'b1;
        repeat (3) step();
        i_retire = 1'b1; i_next_pc = 32'h100;
        step();
        i_retire = 1'b0; i_next_pc = 32'h0;
        #1;
        check("irq_redirect", {63'h0, o_redirect}, 64'h1);
        check("irq_pc", {32'h0, o_pc}, 64'h18);
        check("irq_lr", {32'h0, o_lr}, 64'h104);
        check("irq_no_early_bak", {63'h0, o_spsr_bak}, 64'h0);
        i_redirect_ack = 1'b1;
        #1;
        check("irq_bak", {62'h0, o_spsr_bak, o_lr_we}, 64'h3);
        step();
        i_irq_mask = 1'b1;   // status register sets I on backup
        i_redirect_ack = 1'b0;
        #1;
        check("irq_idle_after", {62'h0, o_busy, o_spsr_bak}, 64'h0);

        // IRQ masked: repeated retires do nothing
        i_retire = 1'b1;
        repeat (6) begin
            i_next_pc = $urandom;
            step();
        end
        check("mask_no_redirect", {63'h0, o_redirect}, 64'h0);

        // SWI and pending IRQ at the same retire
        i_irq_mask = 1'b0;
        i_swi = 1'b1; i_next_pc = 32'h200;
        step();
        i_retire = 1'b0; i_swi = 1'b0;
        #1;
        check("swi_pc", {32'h0, o_pc}, 64'h08);
        check("swi_lr", {32'h0, o_lr}, 64'h200);
        i_redirect_ack = 1'b1;
        step();
        i_irq_mask = 1'b1; i_int_mode = 1'b1; i_redirect_ack = 1'b0;
        i_retire = 1'b1;
        repeat (3) step();
        check("swi_no_irq_after", {63'h0, o_busy}, 64'h0);

        // Exception return, then eret outside exception mode
        i_eret = 1'b1; i_lr = 32'h104;
        step();
        i_retire = 1'b0; i_eret = 1'b0;
        #1;
        check("eret_pc", {32'h0, o_pc}, 64'h104);
        check("eret_res_pre", {63'h0, o_spsr_res}, 64'h0);
        step();
        i_redirect_ack = 1'b1;
        #1;
        check("eret_res", {63'h0, o_spsr_res}, 64'h1);
        step();
        #1;
        check("eret_res_once", {63'h0, o_spsr_res}, 64'h0);
        i_int_mode = 1'b0; i_retire = 1'b1; i_eret = 1'b1; i_lr = 32'h300;
        step();
        check("eret_user_ignored", {63'h0, o_busy}, 64'h0);

        // Ack held low 5 cycles, then en low while acked
        idle_inputs();
        i_irq_mask = 1'b0; i_irq = 1'b1;
        i_retire = 1'b1; i_next_pc = 32'h400;
        step();
        i_retire = 1'b0;
        repeat (5) step();
        en = 1'b0; i_redirect_ack = 1'b1;
        repeat (2) step();
        #1;
        check("hold_pc", {32'h0, o_pc}, 64'h18);
        check("hold_lr", {32'h0, o_lr}, 64'h404);
        check("hold_no_strobe", {63'h0, o_spsr_bak}, 64'h0);
        en = 1'b1;
        #1;
        check("hold_strobe", {63'h0, o_lr_we}, 64'h1);
        step();

        // Reset in the middle of an IRQ entry
        i_redirect_ack = 1'b0; i_retire = 1'b1; i_next_pc = 32'h500;
        step();
        i_retire = 1'b0; i_redirect_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", {o_busy, o_redirect, o_spsr_bak, o_spsr_res, o_lr_we, o_pc, o_lr[26:0]}, 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        i_irq = 1'b0;
        repeat (3) step();

        // IRQ visibility latency: retire every cycle from the edge
        i_irq = 1'b1; i_retire = 1'b1;
        first = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_busy && first < 0) first = k;
        end
        check("irq_vis_latency", 64'(first), 64'(LAT));
        i_retire = 1'b0; i_redirect_ack = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            en             = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 9) == 0) i_irq = ~i_irq;
            i_irq_mask     = ($urandom_range(0, 9) < 3);
            i_int_mode     = $urandom_range(0, 1);
            i_retire       = ($urandom_range(0, 9) < 4);
            i_swi          = ($urandom_range(0, 99) < 15);
            i_eret         = ($urandom_range(0, 99) < 25);
            i_redirect_ack = $urandom_range(0, 1);
            i_next_pc      = $urandom;
            i_lr           = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception sequencer for the ARMv4 core. It decides when to take an IRQ or SWI and when to perform an exception return. It then drives the status-register backup/restore strobes (`spsr_bak`/`spsr_res`), the banked-LR write and the PC redirect. It sits between the decode/retire stage, the fetch unit and the status register, and consumes the status register's `int_mode` and `irq_mask` outputs.

## Interface
- `VEC_BASE`, default 32'h0000_0000: exception vector base.
  - IRQ vector = `VEC_BASE`+32'h18.
  - SWI vector = `VEC_BASE`+32'h08.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: core advance enable. No state change and no strobe while low.
- `i_irq` in 1: external IRQ request, level-sensitive, may be asynchronous.
- `i_irq_mask` in 1: current CPSR I bit.
- `i_int_mode` in 1: current CPSR mode bit (1 = exception mode).
- `i_retire` in 1: an instruction completes this cycle (instruction boundary).
- `i_swi` in 1: the retiring instruction is SWI. Valid with `i_retire`.
- `i_eret` in 1: the retiring instruction is an exception return. Valid with `i_retire`.
- `i_next_pc` in 32: address of the instruction following the retiring one.
- `i_lr` in 32: current banked LR, used as the return target.
- `o_busy` out 1: sequencer not IDLE. The core must not retire while high.
- `o_redirect` out 1: PC redirect request. Held until acknowledged.
- `o_pc` out 32: redirect target.
- `i_redirect_ack` in 1: fetch accepts redirect and flushes the pipeline.
- `o_spsr_bak` out 1: backup strobe to the status register (exception entry).
- `o_spsr_res` out 1: restore strobe to the status register (exception return).
- `o_lr_we` out 1: banked-LR write strobe.
- `o_lr` out 32: value to write to the banked LR.

## Operation
- States: IDLE, ENTER_IRQ, ENTER_SWI, RETURN. The state register advances only when `en`=1.
- IRQ pending: `irq_pend` = synchronized `i_irq` & ~`i_irq_mask`. No latching: a request deasserted before a boundary is lost.
- IDLE, when `i_retire`=1, decide in this priority order:
  1. `i_swi` → ENTER_SWI.
  2. `i_eret` & `i_int_mode` → RETURN.
  3. `irq_pend` → ENTER_IRQ.
  4. Otherwise stay in IDLE.
- Rationale for the order: synchronous events belong to the retiring instruction, so they are handled first. The IRQ stays pending and is reconsidered at a later boundary.
- `i_eret` with `i_int_mode`=0 is ignored and treated as an ordinary instruction.
- On entering a non-IDLE state, capture `i_next_pc` (and, for RETURN, `i_lr`) into an internal `ret_pc`.

Per-state outputs:
- ENTER_IRQ:
  - `o_redirect`=1, `o_pc`=IRQ vector.
  - `o_lr`=`ret_pc`+4.
- ENTER_SWI:
  - `o_redirect`=1, `o_pc`=SWI vector.
  - `o_lr`=`ret_pc`.
- RETURN:
  - `o_redirect`=1, `o_pc`=captured `i_lr`.

Commit:
- Commit cycle = `i_redirect_ack` & `en` in a non-IDLE state.
- ENTER states: assert `o_spsr_bak` and `o_lr_we` for that cycle only.
- RETURN: assert `o_spsr_res` for that cycle only.
- After the commit, go to IDLE.
- Strobes are combinational, gated by state & `i_redirect_ack` & `en`. They are never asserted outside a commit cycle.

No nesting:
- The IRQ mask is set by the status register on the backup strobe, so an IRQ cannot nest.
- SWI while `i_int_mode`=1 is still taken. The saved PSR is overwritten; this is documented behaviour.

## Timing
- Reset values:
  - State IDLE.
  - All 1-bit outputs 0, `o_pc`=0, `o_lr`=0.
  - Synchronizer flops 0.
- Decision latency: `i_retire` in cycle N → `o_redirect`=1 from cycle N+1 (registered state).
- Earliest commit is cycle N+1, if the ack is already high.
- `o_redirect`, `o_pc` and `o_lr` are stable from entry until the commit cycle, including while `en`=0 or the ack is low.
- Back-to-back: IDLE in N+2 after an N+1 commit. A new decision is possible on the next `i_retire`.
- `i_retire` while `o_busy`=1 is ignored.
- Reset asserted mid-sequence: immediate IDLE, all strobes 0, and the pending redirect is dropped. The status register is reset in the same event.

## Configuration
- `EXC_CTRL_IRQ_SYNC_EN` defined:
  - `i_irq` passes through a 2-flop synchronizer (reset 0, clocked every cycle regardless of `en`).
  - An IRQ edge in cycle K is visible to the decision from cycle K+2.
- Not defined:
  - `i_irq` is used directly. The source must be synchronous to `clk`.
  - Visible in cycle K.

## Test plan
- `i_irq`=1, `i_irq_mask`=0, `i_retire` pulsed with `i_next_pc`=32'h100:
  - `o_redirect`=1, `o_pc`=32'h18 the next cycle.
  - With ack: `o_spsr_bak`=1 and `o_lr_we`=1 with `o_lr`=32'h104 for exactly 1 cycle, then IDLE.
- `i_irq`=1, `i_irq_mask`=1, repeated retires: no redirect and no strobes ever.
- `i_swi`=1 and `i_irq` pending at the same retire, `i_next_pc`=32'h200:
  - ENTER_SWI, `o_pc`=32'h08, `o_lr`=32'h200.
  - IRQ is not taken afterwards because the mask is now 1.
- `i_eret`=1, `i_int_mode`=1, `i_lr`=32'h104:
  - `o_pc`=32'h104.
  - `o_spsr_res`=1 on the ack cycle only.
  - Repeat with `i_int_mode`=0: no action.
- Ack held low for 5 cycles, then `en`=0 during ack:
  - Outputs hold and no strobes.
  - The strobe fires only on the cycle where `en`=1 and ack=1.
- `rst_n` asserted while in ENTER_IRQ: all outputs 0 immediately. `i_irq` edge → decision visible after 2 cycles (macro defined) / 0 cycles (not defined).
